// File: rtl/sig_pkg.sv
// Shared types, widths and the observation-bus scramble for the signature compactor.
package sig_pkg;

   localparam int SIG_W  = 16;
   localparam int STIM_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // XOR-fold of every processor observation bus plus the run seed into one byte.
   function automatic logic [7:0] scramble(
      input logic [7:0] seed,
      input logic [3:0] o_reg,
      input logic [3:0] m,
      input logic [3:0] x0,
      input logic [3:0] x1,
      input logic [3:0] y0,
      input logic [3:0] y1,
      input logic [3:0] r,
      input logic       zero_flag,
      input logic [7:0] ir,
      input logic [7:0] pc,
      input logic [7:0] pm_address,
      input logic [7:0] from_ps,
      input logic [7:0] from_id,
      input logic [7:0] from_cu
   );
      return seed ^ {m, o_reg} ^ {x1, x0} ^ {y1, y0} ^ {3'b000, zero_flag, r}
           ^ ir ^ pc ^ pm_address ^ from_ps ^ from_id ^ from_cu;
   endfunction

endpackage

// File: rtl/sig_next_calc.sv
// Next-signature datapath: 8-bit add of the scramble into the low byte, then a
// one-bit left shift in which bit 15 wraps into bit 0.
module sig_next_calc
   import sig_pkg::*;
(
   input  logic [SIG_W-1:0] signature,
   input  logic [7:0]       scr,
   output logic [SIG_W-1:0] next_sig
);

   logic [7:0] add;

   assign add      = signature[7:0] + scr;
   assign next_sig = {signature[14:8], add, signature[15]};

endmodule

// File: rtl/signature_compactor.sv
// Stimulus counter plus signature accumulator wrapped around the processor under test;
// freezes the signature at terminal count and reports pass/fail against expected_sig.
//
//   state | meaning
//   IDLE  | waiting for start; stimulus and signature hold
//   RUN   | one accumulation and counter step per clock until terminal count
//   DONE  | signature, stimulus and pass frozen until start
module signature_compactor
   import sig_pkg::*;
#(
   parameter logic [STIM_W-1:0] TERMINAL_COUNT = 8'hFF,
   parameter bit                AUTO_START     = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        seed,
   input  logic [SIG_W-1:0]  expected_sig,
   input  logic [3:0]        o_reg,
   input  logic [3:0]        m,
   input  logic [3:0]        x0,
   input  logic [3:0]        x1,
   input  logic [3:0]        y0,
   input  logic [3:0]        y1,
   input  logic [3:0]        r,
   input  logic              zero_flag,
   input  logic [7:0]        ir,
   input  logic [7:0]        pc,
   input  logic [7:0]        pm_address,
   input  logic [7:0]        from_PS,
   input  logic [7:0]        from_ID,
   input  logic [7:0]        from_CU,
   output logic [STIM_W-1:0] stimulus,
   output logic [SIG_W-1:0]  signature,
   output logic              busy,
   output logic              done,
   output logic              pass
);

   localparam state_t RESET_STATE = AUTO_START ? RUN : IDLE;

   state_t              state_q, state_d;
   logic [STIM_W-1:0]   stim_d;
   logic [SIG_W-1:0]    sig_d;
   logic                pass_d;
   logic [7:0]          scr;
   logic [SIG_W-1:0]    next_sig;

   assign scr = scramble(seed, o_reg, m, x0, x1, y0, y1, r, zero_flag,
                         ir, pc, pm_address, from_PS, from_ID, from_CU);

   sig_next_calc u_next (
      .signature (signature),
      .scr       (scr),
      .next_sig  (next_sig)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RESET_STATE;
         stimulus  <= '0;
         signature <= '0;
         pass      <= 1'b0;
      end else begin
         state_q   <= state_d;
         stimulus  <= stim_d;
         signature <= sig_d;
         pass      <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stim_d  = stimulus;
      sig_d   = signature;
      pass_d  = pass;
      case (state_q)
         IDLE: begin
            if (start) begin
               stim_d  = '0;
               sig_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stimulus != TERMINAL_COUNT) begin
               sig_d  = next_sig;
               stim_d = stimulus + STIM_W'(1);
            end else begin
               state_d = DONE;
               pass_d  = (signature == expected_sig);
            end
         end
         DONE: begin
            if (start) begin
               stim_d  = '0;
               sig_d   = '0;
               pass_d  = 1'b0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            pass_d  = 1'b0;
         end
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_signature_compactor.sv
// Randomized scoreboard bench for signature_compactor: an abstract model predicts every
// post-edge output set, and a monitor pops and compares one entry per clock.
`timescale 1ns/1ps
module tb_signature_compactor;

   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, reset_b, start_b;
   logic [7:0]  seed;
   logic [15:0] expected_sig;
   logic [3:0]  o_reg, m, x0, x1, y0, y1, r;
   logic        zero_flag;
   logic [7:0]  ir, pc, pm_address, from_PS, from_ID, from_CU;

   logic [7:0]  stimulus_a, stimulus_b;
   logic [15:0] signature_a, signature_b;
   logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;

   signature_compactor dut_a (
      .clk(clk), .reset(reset), .start(start), .seed(seed), .expected_sig(expected_sig),
      .o_reg(o_reg), .m(m), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .zero_flag(zero_flag),
      .ir(ir), .pc(pc), .pm_address(pm_address), .from_PS(from_PS), .from_ID(from_ID),
      .from_CU(from_CU), .stimulus(stimulus_a), .signature(signature_a), .busy(busy_a),
      .done(done_a), .pass(pass_a)
   );

   signature_compactor #(.AUTO_START(1'b0)) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .seed(seed), .expected_sig(expected_sig),
      .o_reg(o_reg), .m(m), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .zero_flag(zero_flag),
      .ir(ir), .pc(pc), .pm_address(pm_address), .from_PS(from_PS), .from_ID(from_ID),
      .from_CU(from_CU), .stimulus(stimulus_b), .signature(signature_b), .busy(busy_b),
      .done(done_b), .pass(pass_b)
   );

   int tests = 0;
   int fails = 0;

   logic [26:0] exp_q[$];
   logic [26:0] mon_exp, mon_act;

   int m_st   = M_IDLE;
   int m_stim = 0;
   int m_sig  = 0;
   bit m_pass = 1'b0;

   // Monitor: one expected output set per clock edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {stimulus_a, signature_a, busy_a, done_a, pass_a};
            tests++;
            if (mon_act !== mon_exp) begin
               fails++;
               $display("FAIL scoreboard t=%0t: got stim=%h sig=%h busy=%b done=%b pass=%b, need stim=%h sig=%h busy=%b done=%b pass=%b",
                        $time, mon_act[26:19], mon_act[18:3], mon_act[2], mon_act[1], mon_act[0],
                        mon_exp[26:19], mon_exp[18:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
         end
      end
   end

   function automatic int model_scramble();
      int s;
      s = seed ^ ((m << 4) | o_reg) ^ ((x1 << 4) | x0) ^ ((y1 << 4) | y0)
        ^ ((zero_flag << 4) | r) ^ ir ^ pc ^ pm_address ^ from_PS ^ from_ID ^ from_CU;
      return s & 'hFF;
   endfunction

   // Predict dut_a outputs after the coming edge from the current inputs.
   task automatic model_step();
      int low;
      if (reset) begin
         m_st = M_RUN; m_stim = 0; m_sig = 0; m_pass = 1'b0;
      end else if (m_st == M_IDLE) begin
         if (start) begin m_stim = 0; m_sig = 0; m_st = M_RUN; end
      end else if (m_st == M_RUN) begin
         if (m_stim != 255) begin
            low    = ((m_sig & 'hFF) + model_scramble()) % 256;
            m_sig  = ((m_sig * 2) & 'hFE00) | (low * 2) | (m_sig / 32768);
            m_stim = m_stim + 1;
         end else begin
            m_st   = M_DONE;
            m_pass = (m_sig == int'(expected_sig));
         end
      end else begin
         if (start) begin m_stim = 0; m_sig = 0; m_pass = 1'b0; m_st = M_RUN; end
      end
      exp_q.push_back({m_stim[7:0], m_sig[15:0], m_st == M_RUN, m_st == M_DONE, m_pass});
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, need %h", name, act, req);
      end
   endtask

   task automatic zero_obs();
      seed = 0; o_reg = 0; m = 0; x0 = 0; x1 = 0; y0 = 0; y1 = 0; r = 0; zero_flag = 0;
      ir = 0; pc = 0; pm_address = 0; from_PS = 0; from_ID = 0; from_CU = 0;
   endtask

   task automatic rand_obs();
      seed = 8'($urandom); o_reg = 4'($urandom); m = 4'($urandom); x0 = 4'($urandom);
      x1 = 4'($urandom); y0 = 4'($urandom); y1 = 4'($urandom); r = 4'($urandom);
      zero_flag = 1'($urandom); ir = 8'($urandom); pc = 8'($urandom);
      pm_address = 8'($urandom); from_PS = 8'($urandom); from_ID = 8'($urandom);
      from_CU = 8'($urandom);
   endtask

   task automatic run_to_done(output int edges);
      edges = 0;
      while (!done_a && edges < 400) begin
         tick();
         edges++;
      end
      if (!done_a) begin
         tests++;
         fails++;
         $display("FAIL run timeout: got done=%b after %0d edges, need done=1", done_a, edges);
      end
   endtask

   initial begin
      int n;
      reset = 1; reset_b = 1; start = 0; start_b = 0; expected_sig = 16'h0000;
      zero_obs();
      tick();
      tick();
      check("reset stimulus", stimulus_a, 8'h00);
      check("reset signature", signature_a, 16'h0000);
      check("reset done", done_a, 1'b0);
      check("reset pass", pass_a, 1'b0);
      check("reset busy (auto start)", busy_a, 1'b1);

      // all-zero run
      reset = 0;
      run_to_done(n);
      check("zero run length", n, 256);
      check("zero run stimulus", stimulus_a, 8'hFF);
      check("zero run signature", signature_a, 16'h0000);
      check("zero run pass", pass_a, 1'b1);

      // DONE ignores expected_sig and seed
      expected_sig = 16'h1234; seed = 8'h5A;
      tick();
      check("done frozen pass", pass_a, 1'b1);
      check("done frozen signature", signature_a, 16'h0000);

      // fail path
      seed = 8'h00; start = 1;
      tick();
      start = 0;
      check("restart done", done_a, 1'b0);
      check("restart stimulus", stimulus_a, 8'h00);
      check("restart busy", busy_a, 1'b1);
      run_to_done(n);
      check("fail path pass", pass_a, 1'b0);
      check("fail path done", done_a, 1'b1);

      // seed 01 sequence
      seed = 8'h01; start = 1;
      tick();
      start = 0;
      tick(); check("seq sig 1", signature_a, 16'h0002); check("seq stim 1", stimulus_a, 8'h01);
      tick(); check("seq sig 2", signature_a, 16'h0006); check("seq stim 2", stimulus_a, 8'h02);
      tick(); check("seq sig 3", signature_a, 16'h000E); check("seq stim 3", stimulus_a, 8'h03);
      run_to_done(n);

      // seed 80 rotate/wrap
      seed = 8'h80; start = 1;
      tick();
      start = 0;
      tick(); check("rot sig 1", signature_a, 16'h0100);
      tick(); check("rot sig 2", signature_a, 16'h0300);
      tick(); check("rot sig 3", signature_a, 16'h0700);
      run_to_done(n);

      // random runs with a start pulse in RUN; run 1 is set up to pass
      for (int k = 0; k < 3; k++) begin
         start = 1;
         tick();
         n = 0;
         while (!done_a && n < 400) begin
            rand_obs();
            start = (m_stim == 'h10);
            expected_sig = (k == 1 && m_stim == 255) ? m_sig[15:0] : 16'($urandom);
            tick();
            n++;
         end
         start = 0;
         check("random run done", done_a, 1'b1);
         check("random run pass", pass_a, (k == 1) ? 1'b1 : 1'b0);
         rand_obs(); expected_sig = 16'($urandom);
         tick();
         tick();
      end

      // reset mid-run on the auto-start instance
      zero_obs(); seed = 8'h33; start = 1;
      tick();
      start = 0;
      n = 0;
      while (m_stim != 'h40 && n < 100) begin tick(); n++; end
      check("pre-reset stimulus", stimulus_a, 8'h40);
      reset = 1;
      tick();
      reset = 0;
      check("mid reset stimulus", stimulus_a, 8'h00);
      check("mid reset signature", signature_a, 16'h0000);
      check("mid reset busy", busy_a, 1'b1);
      run_to_done(n);

      // AUTO_START=0 instance
      reset_b = 1;
      tick();
      reset_b = 0;
      repeat (5) tick();
      check("b idle busy", busy_b, 1'b0);
      check("b idle stimulus", stimulus_b, 8'h00);
      check("b idle done", done_b, 1'b0);
      start_b = 1;
      tick();
      start_b = 0;
      check("b start busy", busy_b, 1'b1);
      n = 0;
      while (stimulus_b != 8'h40 && n < 100) begin tick(); n++; end
      check("b pre-reset stimulus", stimulus_b, 8'h40);
      reset_b = 1;
      tick();
      reset_b = 0;
      check("b reset stimulus", stimulus_b, 8'h00);
      check("b reset signature", signature_b, 16'h0000);
      check("b reset busy", busy_b, 1'b0);
      repeat (5) tick();
      check("b stays idle", busy_b, 1'b0);
      check("b idle pass", pass_b, 1'b0);
      start_b = 1;
      tick();
      start_b = 0;
      check("b restart busy", busy_b, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/signature_compactor.md
Name: signature_compactor

Overview:
- Synthesizable stimulus-and-signature stage that sits around CME341_latest_microprocessor.
- Upstream role: drives the 8-bit stimulus counter whose upper nibble feeds the processor i_pins.
- Downstream role: folds every processor observation bus into a 16-bit scramble/add/rotate signature once per clock.
- Ends a run at counter terminal count, freezes the signature and compares it against an expected value, giving an on-chip pass/fail with no simulator $display.

Parameters:
- TERMINAL_COUNT, 8'hFF, stimulus value that ends a run; no accumulation occurs at this value.
- AUTO_START, 1, 1 = enter RUN directly out of reset; 0 = wait in IDLE for start.

Ports:
- clk  in  1  system clock, 1 MHz nominal.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- start  in  1  run request, level-sampled; honoured in IDLE and DONE only.
- seed  in  8  run seed, XORed into the scramble every cycle.
- expected_sig  in  16  golden signature, sampled on the DONE-entry edge.
- o_reg, m, x0, x1, y0, y1, r  in  4 each  processor observation nibbles.
- zero_flag  in  1  processor zero flag.
- ir, pc, pm_address, from_PS, from_ID, from_CU  in  8 each  processor observation bytes.
- stimulus  out  8  counter value; stimulus[7:4] drives i_pins.
- signature  out  16  accumulator contents.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1: 1 when signature == expected_sig.

Behaviour:
- States: IDLE, RUN, DONE, encoded in 2 bits. State, stimulus and signature are all registered. There is no delta delay on any output.
- On reset: stimulus=8'h00, signature=16'h0000, done=0, pass=0. State goes to RUN if AUTO_START=1, else IDLE. busy follows state. Reset overrides start and every other input on the same edge.
- Scramble (combinational): scr = seed ^ {m,o_reg} ^ {x1,x0} ^ {y1,y0} ^ {3'b0,zero_flag,r} ^ ir ^ pc ^ pm_address ^ from_PS ^ from_ID ^ from_CU.
- Adder: add = signature[7:0] + scr, 8-bit, carry discarded.
- Rotator: next_sig = {signature[14:8], add, signature[15]}. Bit 15 wraps into bit 0.
- IDLE: stimulus and signature hold. When start=1: clear stimulus and signature, go to RUN.
- RUN, when stimulus != TERMINAL_COUNT: signature <= next_sig and stimulus <= stimulus+1, on the same edge.
- RUN, when stimulus == TERMINAL_COUNT: no accumulation, stimulus holds. Go to DONE, done<=1, pass<=(signature==expected_sig).
- Run length: with TERMINAL_COUNT=FF there are exactly 255 accumulations. done rises on the 256th edge after RUN entry.
- DONE: stimulus, signature and pass are frozen. Changes to expected_sig or seed have no effect. When start=1: clear stimulus, signature, done and pass, then go to RUN.
- start while in RUN is ignored.
- Reset mid-run: the run is aborted and the next state is per AUTO_START. There is no partial signature retention.
- pass is 0 whenever done=0.

Decomposition:
- Shared package sig_pkg holds:
  - state typedef {IDLE, RUN, DONE};
  - SIG_W=16 and STIM_W=8 constants;
  - a function scramble() taking all observation buses plus seed.
- One sub-module, sig_next_calc, is natural. It is purely combinational: adder plus rotator, mapping signature and scr to next_sig.
- Counter, FSM and compare live in the top.

Test Plan:
- Zero signature: all observation inputs 0, seed 00, AUTO_START=1, expected 0000. Release reset → signature stays 0000; done=1 and pass=1 on the 256th edge; stimulus=FF.
- Sequence check: seed 01, all others 0. After edges 1, 2, 3 the signature is 0002, 0006, 000E, with stimulus 01, 02, 03.
- Rotate/wrap: seed 80, all others 0. Signature goes 0100, 0300, 0700. Bit 15 later reappears in bit 0; the model compares every cycle until DONE.
- Fail path: same stimulus as the zero-signature test but expected 1234 → done=1, pass=0. Then start=1 → next edge done=0, stimulus=00, busy=1.
- Reset mid-run: assert reset when stimulus=40 → next edge stimulus=00, signature=0000. With AUTO_START=0, state stays IDLE until start.
- start ignored in RUN: pulse start at stimulus=10 → stimulus continues 11, 12, ... The final signature equals the undisturbed reference-model value.
